// File: rtl/sprite_pos_writer.sv
// Avalon-MM master that flushes dirty sprite position registers to the display on commit.
// Latency: commit -> SCAN next cycle, one cycle per index scanned, write per dirty index, done after last accept.
// Backpressure: write/address/writedata held while waitrequest=1; one commit may queue, further ones set overrun.
module sprite_pos_writer #(
    parameter int NREGS     = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        upd_valid,
    input  logic [3:0]  upd_idx,
    input  logic [7:0]  upd_data,
    input  logic        commit,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [8:0]  address,
    output logic [31:0] writedata,
    output logic        write,
    output logic        chipselect,
    input  logic        waitrequest
);

    typedef enum logic [1:0] {IDLE, SCAN, WRITE, DONE} state_t;

    typedef struct packed {
        logic [8:0]  address;
        logic [31:0] writedata;
        logic        write;
    } bus_t;

    localparam logic [4:0] NREGS5 = 5'(NREGS);
    localparam logic [3:0] LAST   = 4'(NREGS - 1);
    localparam logic [8:0] BASE9  = 9'(BASE_ADDR);

    state_t                  state, state_n;
    logic [3:0]              idx, idx_n;
    logic [NREGS-1:0][7:0]   shadow, shadow_n, shadow_upd;
    logic [NREGS-1:0][7:0]   snap, snap_n;
    logic [NREGS-1:0]        dirty, dirty_n, dirty_upd;
    logic [NREGS-1:0]        pending, pending_n, pending_rest;
    logic                    queued, queued_n;
    logic                    overrun_n;
    logic                    busy_n, done_n;
    logic                    upd_hit, capture;
    bus_t                    bus_q, bus_n;

    always_comb begin
        upd_hit    = upd_valid && ({1'b0, upd_idx} < NREGS5);
        shadow_upd = shadow;
        dirty_upd  = dirty;
        if (upd_hit) begin
            shadow_upd[upd_idx] = upd_data;
            dirty_upd[upd_idx]  = 1'b1;
        end

        pending_rest      = pending;
        pending_rest[idx] = 1'b0;

        state_n   = state;
        idx_n     = idx;
        shadow_n  = shadow_upd;
        dirty_n   = dirty_upd;
        snap_n    = snap;
        pending_n = pending;
        queued_n  = queued;
        overrun_n = overrun;
        bus_n     = bus_q;
        capture   = 1'b0;

        case (state)
            IDLE: begin
                // A commit queued during the final DONE cycle is picked up here.
                if (commit || queued) begin
                    queued_n = 1'b0;
                    if (dirty_upd == '0) begin
                        state_n = DONE;
                    end else begin
                        capture = 1'b1;
                        idx_n   = 4'd0;
                        state_n = SCAN;
                    end
                end
            end
            SCAN: begin
                if (pending[idx]) begin
                    bus_n.address   = BASE9 + {5'b0, idx};
                    bus_n.writedata = {24'b0, snap[idx]};
                    bus_n.write     = 1'b1;
                    state_n         = WRITE;
                end else if (idx == LAST) begin
                    state_n = DONE;
                end else begin
                    idx_n = idx + 4'd1;
                end
            end
            WRITE: begin
                if (!waitrequest) begin
                    bus_n.write = 1'b0;
                    pending_n   = pending_rest;
                    // Nothing left above this index: finish without scanning the tail.
                    if (idx == LAST || pending_rest == '0) begin
                        state_n = DONE;
                    end else begin
                        idx_n   = idx + 4'd1;
                        state_n = SCAN;
                    end
                end
            end
            DONE: begin
                if (queued) begin
                    queued_n = 1'b0;
                    capture  = 1'b1;
                    idx_n    = 4'd0;
                    state_n  = SCAN;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (commit && state != IDLE) begin
            if (queued) begin
                overrun_n = 1'b1;
            end else begin
                queued_n = 1'b1;
            end
        end

        if (capture) begin
            snap_n    = shadow_upd;
            pending_n = dirty_upd;
            dirty_n   = '0;
        end

        busy_n = (state_n == SCAN) || (state_n == WRITE);
        done_n = (state_n == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            idx     <= 4'd0;
            shadow  <= '0;
            snap    <= '0;
            dirty   <= '0;
            pending <= '0;
            queued  <= 1'b0;
            overrun <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bus_q   <= '0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            shadow  <= shadow_n;
            snap    <= snap_n;
            dirty   <= dirty_n;
            pending <= pending_n;
            queued  <= queued_n;
            overrun <= overrun_n;
            busy    <= busy_n;
            done    <= done_n;
            bus_q   <= bus_n;
        end
    end

    assign address    = bus_q.address;
    assign writedata  = bus_q.writedata;
    assign write      = bus_q.write;
    assign chipselect = bus_q.write;

endmodule

// File: tb/tb_sprite_pos_writer.sv
// Directed bench for sprite_pos_writer: flush ordering, waitrequest hold, queued commits, reset mid-flush.
module tb_sprite_pos_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        upd_valid;
    logic [3:0]  upd_idx;
    logic [7:0]  upd_data;
    logic        commit;
    logic        busy, done, overrun;
    logic [8:0]  address;
    logic [31:0] writedata;
    logic        write, chipselect;
    logic        waitrequest;

    int vectors     = 0;
    int miscompares = 0;

    logic [40:0] wlog[$];

    always #10 clk = ~clk;

    sprite_pos_writer #(.NREGS(10), .BASE_ADDR(0)) dut (
        .clk         (clk),
        .reset       (reset),
        .upd_valid   (upd_valid),
        .upd_idx     (upd_idx),
        .upd_data    (upd_data),
        .commit      (commit),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .address     (address),
        .writedata   (writedata),
        .write       (write),
        .chipselect  (chipselect),
        .waitrequest (waitrequest)
    );

    // Record every accepted Avalon write as {address, writedata}.
    always @(posedge clk) begin
        if (!reset && write && !waitrequest) wlog.push_back({address, writedata});
    end

    task automatic post_update(input logic [3:0] i, input logic [7:0] d);
        upd_valid = 1'b1;
        upd_idx   = i;
        upd_data  = d;
        @(posedge clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic pulse_commit;
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_write(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (write === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; upd_valid = 1'b0; upd_idx = 4'd0; upd_data = 8'd0;
        commit = 1'b0; waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        vectors++; if (write !== 1'b0 || chipselect !== 1'b0) begin miscompares++; $display("FAIL reset_write: got %b/%b want 0/0", write, chipselect); end
        vectors++; if (address !== 9'd0) begin miscompares++; $display("FAIL reset_address: got %h want 0", address); end
        vectors++; if (writedata !== 32'd0) begin miscompares++; $display("FAIL reset_writedata: got %h want 0", writedata); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_two_writes;
        bit ok;
        logic [40:0] exp0, exp1;
        exp0 = {9'd0, 32'h40};
        exp1 = {9'd1, 32'h50};
        wlog.delete();
        post_update(4'd0, 8'h40);
        post_update(4'd1, 8'h50);
        pulse_commit;
        wait_done(60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL two_done_timeout: got no done want done"); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL two_busy_at_done: got %b want 0", busy); end
        vectors++;
        if (wlog.size() != 2) begin
            miscompares++; $display("FAIL two_count: got %0d writes want 2", wlog.size());
        end else begin
            vectors++; if (wlog[0] !== exp0) begin miscompares++; $display("FAIL two_first: got %h want %h", wlog[0], exp0); end
            vectors++; if (wlog[1] !== exp1) begin miscompares++; $display("FAIL two_second: got %h want %h", wlog[1], exp1); end
        end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL two_done_width: got %b want 0", done); end
    endtask

    task automatic test_empty_commit;
        wlog.delete();
        commit = 1'b1;
        @(posedge clk); #1;
        commit = 1'b0;
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL empty_done: got %b want 1", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy1: got %b want 0", busy); end
        @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL empty_done_low: got %b want 0", done); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL empty_busy2: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        vectors++; if (wlog.size() != 0) begin miscompares++; $display("FAIL empty_writes: got %0d want 0", wlog.size()); end
    endtask

    task automatic test_waitreq_hold;
        bit ok;
        logic [40:0] exp;
        exp = {9'd6, 32'h90};
        wlog.delete();
        waitrequest = 1'b1;
        post_update(4'd6, 8'h90);
        pulse_commit;
        wait_write(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL hold_write_timeout: got no write want write"); end
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            vectors++;
            if (write !== 1'b1 || chipselect !== 1'b1 || address !== 9'd6 || writedata !== 32'h90) begin
                miscompares++;
                $display("FAIL hold_cycle%0d: got w=%b cs=%b a=%h d=%h want 1 1 006 00000090", c, write, chipselect, address, writedata);
            end
        end
        waitrequest = 1'b0;
        @(negedge clk);
        vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL hold_write_drop: got %b want 0", write); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL hold_done: got %b want 1", done); end
        vectors++;
        if (wlog.size() != 1) begin
            miscompares++; $display("FAIL hold_count: got %0d want 1", wlog.size());
        end else if (wlog[0] !== exp) begin
            miscompares++; $display("FAIL hold_entry: got %h want %h", wlog[0], exp);
        end
    endtask

    task automatic test_queued_commit;
        bit ok;
        logic [40:0] exp0, exp1;
        exp0 = {9'd2, 32'h11};
        exp1 = {9'd2, 32'h22};
        wlog.delete();
        waitrequest = 1'b0;
        post_update(4'd2, 8'h11);
        pulse_commit;
        post_update(4'd2, 8'h22);
        pulse_commit;
        @(posedge clk); #1;
        pulse_commit;
        wait_done(60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL queue_done1_timeout: got no done want done"); end
        @(negedge clk);
        vectors++; if (busy !== 1'b1 || done !== 1'b0) begin miscompares++; $display("FAIL queue_restart: got busy=%b done=%b want 1 0", busy, done); end
        wait_done(60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL queue_done2_timeout: got no done want done"); end
        vectors++;
        if (wlog.size() != 2) begin
            miscompares++; $display("FAIL queue_count: got %0d want 2", wlog.size());
        end else begin
            vectors++; if (wlog[0] !== exp0) begin miscompares++; $display("FAIL queue_first: got %h want %h", wlog[0], exp0); end
            vectors++; if (wlog[1] !== exp1) begin miscompares++; $display("FAIL queue_second: got %h want %h", wlog[1], exp1); end
        end
        vectors++; if (overrun !== 1'b1) begin miscompares++; $display("FAIL queue_overrun: got %b want 1", overrun); end
    endtask

    task automatic test_forward_and_range;
        bit ok;
        logic [40:0] exp;
        exp = {9'd9, 32'hAA};
        wlog.delete();
        post_update(4'd12, 8'hFF);
        upd_valid = 1'b1; upd_idx = 4'd9; upd_data = 8'hAA; commit = 1'b1;
        @(posedge clk); #1;
        upd_valid = 1'b0; commit = 1'b0;
        wait_done(60, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL fwd_done_timeout: got no done want done"); end
        vectors++;
        if (wlog.size() != 1) begin
            miscompares++; $display("FAIL fwd_count: got %0d want 1", wlog.size());
        end else if (wlog[0] !== exp) begin
            miscompares++; $display("FAIL fwd_entry: got %h want %h", wlog[0], exp);
        end
        @(negedge clk);
        pulse_commit;
        @(negedge clk);
        vectors++; if (done !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL fwd_clean: got done=%b busy=%b want 1 0", done, busy); end
        repeat (3) @(negedge clk);
        vectors++; if (wlog.size() != 1) begin miscompares++; $display("FAIL fwd_extra_writes: got %0d want 1", wlog.size()); end
    endtask

    task automatic test_reset_mid_flush;
        bit ok;
        wlog.delete();
        waitrequest = 1'b1;
        post_update(4'd3, 8'h33);
        pulse_commit;
        wait_write(40, ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rst_write_timeout: got no write want write"); end
        #3 reset = 1'b1;
        #1;
        vectors++; if (write !== 1'b0 || chipselect !== 1'b0) begin miscompares++; $display("FAIL rst_write_drop: got %b/%b want 0/0", write, chipselect); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy_drop: got %b want 0", busy); end
        vectors++; if (overrun !== 1'b0) begin miscompares++; $display("FAIL rst_overrun_clear: got %b want 0", overrun); end
        @(posedge clk); #1;
        reset = 1'b0;
        waitrequest = 1'b0;
        @(posedge clk); #1;
        pulse_commit;
        @(negedge clk);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL rst_after_done: got %b want 1", done); end
        repeat (4) @(negedge clk);
        vectors++; if (wlog.size() != 0) begin miscompares++; $display("FAIL rst_after_writes: got %0d want 0", wlog.size()); end
    endtask

    initial begin
        test_reset;
        test_two_writes;
        test_empty_commit;
        test_waitreq_hold;
        test_queued_commit;
        test_forward_and_range;
        test_reset_mid_flush;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
